// File: rtl/activation_lut_loader.sv
// Writable breakpoint table for the activation interpolator: a valid/ready
// load port fills 2^ADDR_W+1 signed samples, and a zero-latency read port serves {base, next_data}.
module activation_lut_loader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_start,
  input  logic                     load_valid,
  input  logic signed [DATA_W-1:0] load_data,
  output logic                     load_ready,
  output logic                     load_done,
  output logic                     table_valid,
  input  logic        [ADDR_W-1:0] address,
  output logic signed [DATA_W-1:0] base,
  output logic signed [DATA_W-1:0] next_data
);

  localparam int DEPTH = (1 << ADDR_W) + 1;
  localparam logic [ADDR_W:0] LAST = (ADDR_W + 1)'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t                   state, state_next;
  logic [ADDR_W:0]          count, count_next;
  logic                     table_valid_next;
  logic                     wr_en;
  logic signed [DATA_W-1:0] lut [DEPTH];
  logic [ADDR_W:0]          rd_addr, rd_addr_next;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_next       = state;
    count_next       = count;
    table_valid_next = table_valid;
    wr_en            = 1'b0;
    load_done        = 1'b0;
    unique case (state)
      IDLE: begin
        if (load_start) begin
          state_next       = LOAD;
          count_next       = '0;
          table_valid_next = 1'b0;
        end
      end
      LOAD: begin
        // A restart wins over a coincident sample; the sample is dropped.
        if (load_start) begin
          count_next = '0;
        end else if (load_valid && load_ready) begin
          wr_en      = 1'b1;
          count_next = count + 1'b1;
          if (count == LAST) begin
            state_next       = DONE;
            table_valid_next = 1'b1;
          end
        end
      end
      DONE: begin
        load_done  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      count       <= '0;
      load_ready  <= 1'b0;
      table_valid <= 1'b0;
    end else begin
      state       <= state_next;
      count       <= count_next;
      load_ready  <= (state_next == LOAD);
      table_valid <= table_valid_next;
    end
  end

  // NOTE: the table is a small register file, not a RAM macro, so it can and
  // does take the synchronous reset; no stale data survives a reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) lut[i] <= '0;
    end else if (wr_en) begin
      lut[count] <= load_data;
    end
  end

  // One extra address bit so address+1 reaches entry 16 instead of wrapping.
  assign rd_addr      = {1'b0, address};
  assign rd_addr_next = rd_addr + 1'b1;

  assign base      = table_valid ? lut[rd_addr]      : '0;
  assign next_data = table_valid ? lut[rd_addr_next] : '0;

endmodule
